// File: rtl/mem_access_unit.sv
// Memory access unit: turns load/store requests from a multicycle controller
// into one word-aligned bus transaction, with alignment check and ack timeout.
module mem_access_unit #(
  parameter int unsigned N       = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [N-1:0] addr,
  input  logic [N-1:0] wdata,
  output logic [N-1:0] rdata,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         bus_req,
  output logic         bus_we,
  output logic [N-1:0] bus_addr,
  output logic [N-1:0] bus_wdata,
  input  logic         bus_ack,
  input  logic [N-1:0] bus_rdata
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            we_q, we_n;
  logic [N-1:0]    addr_q, addr_n;
  logic [N-1:0]    wdata_q, wdata_n;
  logic [N-1:0]    rdata_n;
  logic            busy_n, done_n, err_n;
  logic            bus_req_n, bus_we_n;
  logic [N-1:0]    bus_addr_n, bus_wdata_n;

  // State and registered outputs; outputs are decoded from the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      we_q      <= we_n;
      addr_q    <= addr_n;
      wdata_q   <= wdata_n;
      rdata     <= rdata_n;
      busy      <= busy_n;
      done      <= done_n;
      err       <= err_n;
      bus_req   <= bus_req_n;
      bus_we    <= bus_we_n;
      bus_addr  <= bus_addr_n;
      bus_wdata <= bus_wdata_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    we_n    = we_q;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    rdata_n = rdata;
    err_n   = 1'b0;

    case (state)
      IDLE: begin
        if (mem_read || mem_write) begin
          we_n    = mem_write;
          addr_n  = addr;
          wdata_n = wdata;
          cnt_n   = '0;
          if (addr[1:0] != 2'b00) begin
            state_n = DONE;
            err_n   = 1'b1;
          end else begin
            state_n = REQ;
          end
        end
      end
      REQ: begin
        // An ack on the final wait cycle still completes the access cleanly.
        if (bus_ack) begin
          if (!we_q) rdata_n = bus_rdata;
          state_n = DONE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_n = DONE;
          err_n   = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    busy_n      = (state_n == REQ);
    done_n      = (state_n == DONE);
    bus_req_n   = (state_n == REQ);
    bus_we_n    = (state_n == REQ) && we_n;
    bus_addr_n  = (state_n == REQ) ? (addr_n >> 2) : '0;
    bus_wdata_n = (state_n == REQ) ? wdata_n : '0;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: vector table of transactions checked through an
// expected-result queue, plus a hand-written mid-transaction reset sequence.
module tb_mem_access_unit;

  localparam int unsigned N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         mem_read, mem_write;
  logic [N-1:0] addr, wdata;
  logic [N-1:0] rdata;
  logic         busy, done, err;
  logic         bus_req, bus_we;
  logic [N-1:0] bus_addr, bus_wdata;
  logic         bus_ack;
  logic [N-1:0] bus_rdata;

  mem_access_unit #(.N(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
    .err(err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  // ack_at: REQ cycle (1-based) in which bus_ack is raised; 0 means never.
  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack_at;
    logic [31:0] ack_data;
    logic        exp_err;
    int          exp_req;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic        err;
    logic        we;
    int          req;
    int          lat;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[10];
  logic [31:0] model_rdata;
  int          n_vec  = 0;
  int          n_miss = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic run_txn(input vec_t v);
    exp_t e;
    int   reqc;
    bit   seen;
    reqc = 0;
    seen = 1'b0;
    @(negedge clk);
    mem_read  = v.rd;
    mem_write = v.wr;
    addr      = v.addr;
    wdata     = v.wdata;
    e.err = v.exp_err;
    e.we  = v.wr;
    e.req = v.exp_req;
    e.lat = v.exp_lat;
    if (!v.exp_err && !v.wr) model_rdata = v.ack_data;
    e.rdata = model_rdata;
    sb.push_back(e);
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      // Inputs wander after capture; the unit must ignore them.
      mem_read  = 1'b0;
      mem_write = 1'b0;
      addr      = $urandom;
      wdata     = $urandom;
      bus_ack   = 1'b0;
      bus_rdata = $urandom;
      if (bus_req) begin
        reqc++;
        chk("bus_addr", bus_addr, v.addr >> 2);
        chk("bus_we", 32'(bus_we), 32'(v.wr));
        chk("bus_wdata", bus_wdata, v.wdata);
        chk("busy_in_req", 32'(busy), 32'd1);
        if (reqc == v.ack_at) begin
          bus_ack   = 1'b1;
          bus_rdata = v.ack_data;
        end
      end else if (done) begin
        seen = 1'b1;
        e = sb.pop_front();
        chk("err", 32'(err), 32'(e.err));
        chk("rdata", rdata, e.rdata);
        chk("req_cycles", 32'(reqc), 32'(e.req));
        chk("latency", 32'(c), 32'(e.lat));
        chk("busy_in_done", 32'(busy), 32'd0);
        chk("bus_we_in_done", 32'(bus_we), 32'd0);
      end else begin
        chk("unexpected_idle", 32'(c), 32'd0);
      end
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus_ack = 1'b0;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_bus_req", 32'(bus_req), 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'h10,       32'h0,        1,  32'hDEADBEEF, 1'b0, 1,  2};
    vecs[1] = '{1'b0, 1'b1, 32'h8,        32'h12345678, 3,  32'h0,        1'b0, 3,  4};
    vecs[2] = '{1'b1, 1'b0, 32'h6,        32'h0,        0,  32'h0,        1'b1, 0,  1};
    vecs[3] = '{1'b1, 1'b0, 32'h20,       32'h0,        0,  32'h0,        1'b1, 15, 16};
    vecs[4] = '{1'b1, 1'b1, 32'h40,       32'hA5A5A5A5, 2,  32'h11111111, 1'b0, 2,  3};
    vecs[5] = '{1'b1, 1'b0, 32'h44,       32'h0,        15, 32'hCAFEF00D, 1'b0, 15, 16};
    vecs[6] = '{1'b0, 1'b1, 32'h3,        32'h55555555, 0,  32'h0,        1'b1, 0,  1};
    vecs[7] = '{1'b1, 1'b0, 32'hFFFFFFFC, 32'h0,        5,  32'h0BADF00D, 1'b0, 5,  6};
    vecs[8] = '{1'b0, 1'b1, 32'h0,        32'h77777777, 0,  32'h0,        1'b1, 15, 16};
    vecs[9] = '{1'b1, 1'b0, 32'h1,        32'h0,        0,  32'h0,        1'b1, 0,  1};

    model_rdata = 32'h0;
    rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    #1;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_flags", {28'h0, busy, done, err, bus_req}, 32'h0);
    chk("rst_bus", bus_addr | bus_wdata | 32'(bus_we), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) run_txn(vecs[i]);

    // Reset during the second REQ cycle of an unacknowledged read.
    @(negedge clk);
    mem_read = 1'b1; addr = 32'h80;
    @(negedge clk);
    mem_read = 1'b0;
    chk("mid_req1", 32'(bus_req), 32'd1);
    @(negedge clk);
    chk("mid_req2", 32'(bus_req), 32'd1);
    rst = 1'b0;
    #1;
    model_rdata = 32'h0;
    chk("mid_rst_flags", {28'h0, busy, done, err, bus_req}, 32'h0);
    chk("mid_rst_bus", bus_addr | bus_wdata | 32'(bus_we), 32'h0);
    chk("mid_rst_rdata", rdata, model_rdata);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("post_rst_quiet", {29'h0, done, busy, bus_req}, 32'h0);
    end

    run_txn(vecs[0]);
    if (sb.size() != 0) chk("sb_leftover", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
